spi_tx_engine: RTL

SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_sclk_gen.sv | 52 +++++
 rtl/spi_tx_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit engine: FSM states, byte width and
// default bus timing/mode parameters.
package spi_pkg;

    localparam int          BYTE_W       = 8;
    localparam int unsigned DIV_DEFAULT  = 4;
    localparam bit          CPOL_DEFAULT = 1'b0;
    localparam bit          CPHA_DEFAULT = 1'b0;
    localparam logic [4:0]  LAST_EDGE    = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_STORE,
        ST_DESEL
    } state_t;

    function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] v, input logic b);
        return {v[BYTE_W-2:0], b};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timebase and SCLK level generator. The tick doubles as the
// SETUP/DESEL delay; SCLK only toggles while shift_en is high.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV  = DIV_DEFAULT,
    parameter bit          CPOL = CPOL_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic shift_en,
    output logic tick,
    output logic lead,
    output logic trail,
    output logic sclk
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_reg;
    logic       run_reg;
    logic       sclk_reg;

    assign tick  = run_reg && (cnt_reg == 8'd0);
    assign lead  = tick && shift_en && (sclk_reg == CPOL);
    assign trail = tick && shift_en && (sclk_reg != CPOL);
    assign sclk  = sclk_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= 8'd0;
            run_reg  <= 1'b0;
            sclk_reg <= CPOL;
        end else if (start) begin
            cnt_reg <= RELOAD;
            run_reg <= 1'b1;
        end else if (stop) begin
            cnt_reg  <= 8'd0;
            run_reg  <= 1'b0;
            sclk_reg <= CPOL;
        end else if (run_reg) begin
            // Reload on terminal count instead of wrapping through 8'hFF.
            cnt_reg <= (cnt_reg == 8'd0) ? RELOAD : cnt_reg - 8'd1;
            if (tick && shift_en) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

endmodule

// File: rtl/spi_tx_engine.sv
// SPI master byte engine: pops bytes from a TX FIFO, shifts them out MSB first
// while capturing MISO, and pushes received bytes into an RX FIFO.
module spi_tx_engine
    import spi_pkg::*;
#(
    parameter int unsigned DIV  = DIV_DEFAULT,
    parameter bit          CPOL = CPOL_DEFAULT,
    parameter bit          CPHA = CPHA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tx_empty,
    output logic              tx_rd,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              rx_full,
    output logic              rx_wr,
    output logic [BYTE_W-1:0] rx_data,
    output logic              busy,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    state_t            state_reg;
    logic [4:0]        edge_cnt_reg;
    logic [BYTE_W-1:0] tx_sh_reg;
    logic [BYTE_W-1:0] rx_sh_reg;
    logic [BYTE_W-1:0] rx_data_reg;
    logic              cs_n_reg;
    logic              mosi_reg;
    logic              tx_rd_reg;
    logic              ovf_reg;

    logic              tick;
    logic              lead;
    logic              trail;
    logic              gen_start;
    logic              gen_stop;
    logic              shift_en;
    logic              fetch_ok;
    logic [BYTE_W-1:0] rx_sampled;

    assign fetch_ok   = enable && !tx_empty;
    assign rx_sampled = shift_in(rx_sh_reg, miso);
    assign gen_start  = (state_reg == ST_LOAD) || (state_reg == ST_STORE);
    assign gen_stop   = (state_reg == ST_DESEL) && tick;
    assign shift_en   = (state_reg == ST_SHIFT);

    assign tx_rd   = tx_rd_reg;
    assign rx_wr   = (state_reg == ST_STORE) && !rx_full;
    assign rx_data = rx_data_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign ovf     = ovf_reg;
    assign mosi    = mosi_reg;
    assign cs_n    = cs_n_reg;

    spi_sclk_gen #(
        .DIV  (DIV),
        .CPOL (CPOL)
    ) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (gen_start),
        .stop     (gen_stop),
        .shift_en (shift_en),
        .tick     (tick),
        .lead     (lead),
        .trail    (trail),
        .sclk     (sclk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            edge_cnt_reg <= 5'd0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            cs_n_reg     <= 1'b1;
            mosi_reg     <= 1'b0;
            tx_rd_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            tx_rd_reg <= 1'b0;
            // A drop in the same cycle as a clear wins.
            if ((state_reg == ST_STORE) && rx_full) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (fetch_ok) begin
                        state_reg <= ST_FETCH;
                        tx_rd_reg <= 1'b1;
                    end
                end
                ST_FETCH: state_reg <= ST_LOAD;
                ST_LOAD: begin
                    tx_sh_reg <= tx_data;
                    rx_sh_reg <= '0;
                    if (!CPHA) begin
                        mosi_reg <= tx_data[BYTE_W-1];
                    end
                    cs_n_reg  <= 1'b0;
                    state_reg <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if ((lead && CPHA) || (trail && !CPHA)) begin
                        mosi_reg  <= CPHA ? tx_sh_reg[BYTE_W-1] : tx_sh_reg[BYTE_W-2];
                        tx_sh_reg <= tx_sh_reg << 1;
                    end
                    if ((lead && !CPHA) || (trail && CPHA)) begin
                        rx_sh_reg <= rx_sampled;
                    end
                    if (tick) begin
                        if (edge_cnt_reg == LAST_EDGE) begin
                            edge_cnt_reg <= 5'd0;
                            // In CPHA=1 the last sample lands on this same edge.
                            rx_data_reg  <= CPHA ? rx_sampled : rx_sh_reg;
                            state_reg    <= ST_STORE;
                        end else begin
                            edge_cnt_reg <= edge_cnt_reg + 5'd1;
                        end
                    end
                end
                ST_STORE: begin
                    if (fetch_ok) begin
                        state_reg <= ST_FETCH;
                        tx_rd_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_DESEL;
                    end
                end
                ST_DESEL: begin
                    if (tick) begin
                        cs_n_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
